// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned WORD_WIDTH = 32;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_e;

  function automatic int unsigned offset_width(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned tag_width(input int unsigned index_width,
                                            input int unsigned line_words);
    return ADDR_WIDTH - 2 - offset_width(line_words) - index_width;
  endfunction

  // Field extractors return right-justified values; callers cast to the field width.
  function automatic logic [ADDR_WIDTH-1:0] addr_offset(input logic [ADDR_WIDTH-1:0] addr,
                                                        input int unsigned line_words);
    return (addr >> 2) & ((32'd1 << offset_width(line_words)) - 32'd1);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr,
                                                       input int unsigned index_width,
                                                       input int unsigned line_words);
    return (addr >> (2 + offset_width(line_words))) & ((32'd1 << index_width) - 32'd1);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] addr,
                                                     input int unsigned index_width,
                                                     input int unsigned line_words);
    return addr >> (2 + offset_width(line_words) + index_width);
  endfunction

endpackage

// File: rtl/icache_line_refill_if.sv
// Fetch-side and memory-side signals of the instruction cache, bundled as one interface.
interface icache_line_refill_if;
  import icache_pkg::*;

  logic                  fetchValid;
  logic [ADDR_WIDTH-1:0] fetchAddr;
  logic                  fetchReady;
  logic [WORD_WIDTH-1:0] fetchData;
  logic                  flushIn;
  logic                  memReq;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic                  memValid;
  logic [WORD_WIDTH-1:0] memData;

  modport slave (
    input  fetchValid, fetchAddr, flushIn, memValid, memData,
    output fetchReady, fetchData, memReq, memAddr
  );

  modport master (
    output fetchValid, fetchAddr, flushIn, memValid, memData,
    input  fetchReady, fetchData, memReq, memAddr
  );

endinterface

// File: rtl/icache_refill_fsm.sv
// Refill controller: tracks the line being fetched, drives the memory port and
// issues data/tag/valid write strobes to the arrays held in the cache top.
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 6,
  parameter int unsigned LINE_WORDS  = 4,
  localparam int unsigned OFFSET_WIDTH = offset_width(LINE_WORDS),
  localparam int unsigned TAG_WIDTH    = tag_width(INDEX_WIDTH, LINE_WORDS)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    rdy_i,
  input  logic                    fetch_miss_i,
  input  logic [TAG_WIDTH-1:0]    fetch_tag_i,
  input  logic [INDEX_WIDTH-1:0]  fetch_index_i,
  input  logic                    flush_i,
  input  logic                    mem_valid_i,
  output logic                    idle_o,
  output logic                    start_o,
  output logic                    wr_en_o,
  output logic [OFFSET_WIDTH-1:0] wr_offset_o,
  output logic                    done_o,
  output logic                    set_valid_o,
  output logic [TAG_WIDTH-1:0]    miss_tag_o,
  output logic [INDEX_WIDTH-1:0]  miss_index_o,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o
);

  localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = OFFSET_WIDTH'(LINE_WORDS - 1);

  state_e                  state_q, state_d;
  logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
  logic                    discard_q, discard_d;
  logic [TAG_WIDTH-1:0]    miss_tag_q, miss_tag_d;
  logic [INDEX_WIDTH-1:0]  miss_index_q, miss_index_d;

  // NOTE: clocked state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      discard_q    <= 1'b0;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      discard_q    <= discard_d;
      miss_tag_q   <= miss_tag_d;
      miss_index_q <= miss_index_d;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    discard_d    = discard_q;
    miss_tag_d   = miss_tag_q;
    miss_index_d = miss_index_q;
    start_o      = 1'b0;
    wr_en_o      = 1'b0;
    done_o       = 1'b0;
    set_valid_o  = 1'b0;
    mem_addr_o   = '0;

    case (state_q)
      IDLE: begin
        if (rdy_i && fetch_miss_i) begin
          start_o      = 1'b1;
          state_d      = REFILL;
          cnt_d        = '0;
          discard_d    = 1'b0;
          miss_tag_d   = fetch_tag_i;
          miss_index_d = fetch_index_i;
        end
      end
      REFILL: begin
        mem_addr_o = {miss_tag_q, miss_index_q, cnt_q, 2'b00};
        if (rdy_i) begin
          if (flush_i) discard_d = 1'b1;
          if (mem_valid_i) begin
            wr_en_o = 1'b1;
            cnt_d   = cnt_q + OFFSET_WIDTH'(1);
            if (cnt_q == LAST_WORD) begin
              // A flush landing on the final word also suppresses the valid set.
              done_o      = 1'b1;
              set_valid_o = !discard_q && !flush_i;
              state_d     = IDLE;
              discard_d   = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign idle_o       = (state_q == IDLE);
  assign mem_req_o    = (state_q == REFILL);
  assign wr_offset_o  = cnt_q;
  assign miss_tag_o   = miss_tag_q;
  assign miss_index_o = miss_index_q;

endmodule

// File: rtl/icache_line_refill.sv
// Direct-mapped instruction cache with single-cycle hit path, line refill and bulk flush.
// Optional performance counters are enabled by defining ICACHE_PERF_EN.
module icache_line_refill
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 6,
  parameter int unsigned LINE_WORDS  = 4
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic                  rdyIn,
  icache_line_refill_if.slave   bus,
  output logic [31:0]           hitCnt,
  output logic [31:0]           missCnt
);

  localparam int unsigned OFFSET_WIDTH = offset_width(LINE_WORDS);
  localparam int unsigned TAG_WIDTH    = tag_width(INDEX_WIDTH, LINE_WORDS);
  localparam int unsigned LINES        = 1 << INDEX_WIDTH;

  logic [TAG_WIDTH-1:0]    fetch_tag;
  logic [INDEX_WIDTH-1:0]  fetch_index;
  logic [OFFSET_WIDTH-1:0] fetch_offset;

  logic [LINES-1:0]        valid_q, valid_d;
  logic [TAG_WIDTH-1:0]    tag_q  [LINES];
  logic [WORD_WIDTH-1:0]   data_q [LINES*LINE_WORDS];

  logic                    hit, idle, start, wr_en, done, set_valid;
  logic [OFFSET_WIDTH-1:0] wr_offset;
  logic [TAG_WIDTH-1:0]    miss_tag;
  logic [INDEX_WIDTH-1:0]  miss_index;

  assign fetch_tag    = TAG_WIDTH'(addr_tag(bus.fetchAddr, INDEX_WIDTH, LINE_WORDS));
  assign fetch_index  = INDEX_WIDTH'(addr_index(bus.fetchAddr, INDEX_WIDTH, LINE_WORDS));
  assign fetch_offset = OFFSET_WIDTH'(addr_offset(bus.fetchAddr, LINE_WORDS));

  assign hit            = valid_q[fetch_index] && (tag_q[fetch_index] == fetch_tag);
  assign bus.fetchReady = rdyIn && idle && bus.fetchValid && hit && !bus.flushIn;
  assign bus.fetchData  = data_q[{fetch_index, fetch_offset}];

  icache_refill_fsm #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .LINE_WORDS  (LINE_WORDS)
  ) u_fsm (
    .clk_i         (clkIn),
    .rst_ni        (rstIn),
    .rdy_i         (rdyIn),
    .fetch_miss_i  (bus.fetchValid && !hit),
    .fetch_tag_i   (fetch_tag),
    .fetch_index_i (fetch_index),
    .flush_i       (bus.flushIn),
    .mem_valid_i   (bus.memValid),
    .idle_o        (idle),
    .start_o       (start),
    .wr_en_o       (wr_en),
    .wr_offset_o   (wr_offset),
    .done_o        (done),
    .set_valid_o   (set_valid),
    .miss_tag_o    (miss_tag),
    .miss_index_o  (miss_index),
    .mem_req_o     (bus.memReq),
    .mem_addr_o    (bus.memAddr)
  );

  // Valid bits live apart from the tag RAM so a flush is a single-cycle clear.
  always_comb begin
    valid_d = valid_q;
    if (rdyIn) begin
      if (bus.flushIn) valid_d = '0;
      else if (start)  valid_d[fetch_index] = 1'b0;
      if (set_valid)   valid_d[miss_index] = 1'b1;
    end
  end

  always_ff @(posedge clkIn) begin
    if (!rstIn) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // NOTE: tag and data arrays have no reset; the valid vector alone qualifies their contents.
  always_ff @(posedge clkIn) begin
    if (rstIn && wr_en) data_q[{miss_index, wr_offset}] <= bus.memData;
    if (rstIn && done)  tag_q[miss_index] <= miss_tag;
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clkIn) begin
    if (!rstIn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdyIn) begin
      if (bus.fetchReady) hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (start)          miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hitCnt  = hit_cnt_q;
  assign missCnt = miss_cnt_q;
`else
  assign hitCnt  = '0;
  assign missCnt = '0;
`endif

endmodule
